// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out serializer. A WIDTH-bit word is accepted over a
// valid/ready handshake. It is then emitted one bit per clock on `so`, with
// frame markers so a downstream SIPO can find word boundaries. The optional
// inter-word gap is set with GAP_CYCLES.
//
// Optional feature (compile-time macro):
//   PISO_PARITY_EN : appends one even-parity bit (XOR of the data bits) after
//                    the last data bit; the frame becomes WIDTH+1 bits long.
//
// Parameters:
//   WIDTH      : data word width (2..32)
//   MSB_FIRST  : 1 = send bit WIDTH-1 first, 0 = send bit 0 first
//   GAP_CYCLES : idle cycles forced between frames (0..15)
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   pi_data   in   parallel word (sampled only on acceptance)
//   pi_valid  in   pi_data is valid
//   pi_ready  out  word accepted this cycle if pi_valid (combinational)
//   so        out  serial data bit (0 whenever so_valid is 0)
//   so_valid  out  so carries a frame bit
//   so_first  out  first bit of the frame
//   so_last   out  last bit of the frame (last data bit, or parity bit)
//   busy      out  frame in flight (SHIFT, PARITY or GAP)
// -----------------------------------------------------------------------------
module piso_serializer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi_data,
  input  logic             pi_valid,
  output logic             pi_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             so_last,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  // The GAP state is unreachable when GAP_CYCLES is 0, so the load value is
  // only meaningful for GAP_CYCLES >= 1.
  localparam logic [3:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_PARITY} state_e;
`else
  localparam bit PARITY_EN = 1'b0;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;      // head bit is the one currently on so
  logic [CNT_W-1:0] cnt_q, cnt_d;        // data bits remaining after the current one
  logic [3:0]       gap_q, gap_d;        // GAP cycles remaining after the current one
  logic             so_q, so_d;
  logic             so_valid_q, so_valid_d;
  logic             so_first_q, so_first_d;
  logic             so_last_q, so_last_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;        // even parity of the accepted word
`endif

  logic [WIDTH-1:0] sreg_shift;
  logic             last_serial;         // final serial cycle of the current frame
  logic             accept;

  // Bit presented first for a given register content.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  assign sreg_shift = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);

`ifdef PISO_PARITY_EN
  assign last_serial = (state_q == S_PARITY);
`else
  assign last_serial = (state_q == S_SHIFT) && (cnt_q == '0);
`endif

  // Back-to-back streaming: with no gap, the next word may be taken in the
  // final serial cycle so its first bit follows without a bubble.
  assign pi_ready = (state_q == S_IDLE) || ((GAP_CYCLES == 0) && last_serial);
  assign accept   = pi_valid && pi_ready;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    so_d       = 1'b0;
    so_valid_d = 1'b0;
    so_first_d = 1'b0;
    so_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d      = par_q;
`endif

    unique case (state_q)
      S_SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d     = sreg_shift;
          cnt_d      = cnt_q - CNT_W'(1);
          so_d       = head_bit(sreg_shift);
          so_valid_d = 1'b1;
          so_last_d  = (cnt_q == CNT_W'(1)) && !PARITY_EN;
        end
`ifdef PISO_PARITY_EN
        else begin
          state_d    = S_PARITY;
          so_d       = par_q;
          so_valid_d = 1'b1;
          so_last_d  = 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: ;
    endcase

    // End of frame: go through the gap if configured, otherwise back to idle.
    if (last_serial) begin
      if (GAP_CYCLES > 0) begin
        state_d = S_GAP;
        gap_d   = GAP_LOAD;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Acceptance overrides the end-of-frame choice (back-to-back case).
    if (accept) begin
      state_d    = S_SHIFT;
      sreg_d     = pi_data;
      cnt_d      = CNT_LOAD;
      so_d       = head_bit(pi_data);
      so_valid_d = 1'b1;
      so_first_d = 1'b1;
      so_last_d  = 1'b0;
`ifdef PISO_PARITY_EN
      par_d      = ^pi_data;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: the shift register is reset along with the control state; it is a
  // single word, and a known value keeps a discarded partial word from
  // lingering after a mid-frame reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      so_q       <= 1'b0;
      so_valid_q <= 1'b0;
      so_first_q <= 1'b0;
      so_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      so_q       <= so_d;
      so_valid_q <= so_valid_d;
      so_first_q <= so_first_d;
      so_last_q  <= so_last_d;
`ifdef PISO_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign so       = so_q;
  assign so_valid = so_valid_q;
  assign so_first = so_first_q;
  assign so_last  = so_last_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//
// Four serializer instances share clock and reset:
//   cfg0: WIDTH=4 MSB_FIRST=1 GAP=0    cfg1: WIDTH=4 MSB_FIRST=0 GAP=0
//   cfg2: WIDTH=4 MSB_FIRST=1 GAP=2    cfg3: WIDTH=7 MSB_FIRST=0 GAP=3
// Each instance gets directed words first (1011, 0110 for the 4-bit ones),
// then random traffic. On acceptance the driver pushes the expected frame
// (bit, first, last, cycle) into a queue. A monitor pops and compares every
// cycle. pi_ready and busy are predicted from the acceptance time and the
// frame/gap lengths. A mid-frame reset checks the asynchronous clear, and
// word 0001 is sent right after release.
// -----------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  typedef struct {
    int   cyc;
    logic b;
    logic f;
    logic l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   drv_en = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int IDX = g;
    localparam int W   = (g == 3) ? 7 : 4;
    localparam int M   = (g == 1 || g == 3) ? 0 : 1;
    localparam int G   = (g == 2) ? 2 : ((g == 3) ? 3 : 0);
    localparam int L   = W + PAR;

    logic [W-1:0] pi_data;
    logic         pi_valid;
    logic         pi_ready, so, so_valid, so_first, so_last, busy;

    exp_t         exp_q[$];
    logic [W-1:0] dir_q[$];
    int           ready_from = 0;
    int           busy_until = -1;
    bit           flush_pend = 1'b0;
    int           q_left = 0;

    piso_serializer #(
      .WIDTH(W), .MSB_FIRST(M), .GAP_CYCLES(G)
    ) u_dut (
      .clk(clk), .rst(rst), .pi_data(pi_data), .pi_valid(pi_valid),
      .pi_ready(pi_ready), .so(so), .so_valid(so_valid), .so_first(so_first),
      .so_last(so_last), .busy(busy)
    );

    // Reset discards everything in flight; the next word offered is 0..01.
    always @(negedge rst) begin
      if (mon_en) begin
        exp_q.delete();
        ready_from = 0;
        busy_until = -1;
        dir_q.delete();
        dir_q.push_back(W'(1));
        flush_pend = 1'b1;
      end
    end

    initial begin : drv
      exp_t         e;
      logic [W-1:0] w;
      bit           acc, holding, hold_dir;
      int           a;
      pi_valid = 1'b0;
      pi_data  = '0;
      holding  = 1'b0;
      hold_dir = 1'b0;
      if (W == 4) begin
        dir_q.push_back(W'(11));
        dir_q.push_back(W'(6));
      end
      @(posedge rst);
      forever begin
        @(negedge clk);
        acc = (rst === 1'b1) && (pi_valid === 1'b1) && (pi_ready === 1'b1);
        a   = cyc;
        w   = pi_data;
        @(posedge clk);
        #1;
        if (acc) begin
          for (int i = 0; i < L; i++) begin
            e.cyc = a + 1 + i;
            if (i < W) e.b = (M != 0) ? w[W-1-i] : w[i];
            else       e.b = ^w;
            e.f = (i == 0);
            e.l = (i == L - 1);
            exp_q.push_back(e);
          end
          ready_from = a + L + ((G == 0) ? 0 : G + 1);
          busy_until = a + L + G;
          holding    = 1'b0;
        end
        if (flush_pend) begin
          holding    = 1'b0;
          flush_pend = 1'b0;
        end
        if (!drv_en) begin
          pi_valid = 1'b0;
          holding  = 1'b0;
        end else if (holding) begin
          // A waiting random word may change; only the value at acceptance counts.
          if (!hold_dir && $urandom_range(0, 3) == 0) pi_data = W'($urandom);
        end else if (dir_q.size() > 0) begin
          pi_data  = dir_q.pop_front();
          pi_valid = 1'b1;
          holding  = 1'b1;
          hold_dir = 1'b1;
        end else begin
          pi_valid = ($urandom_range(0, 3) != 0);
          pi_data  = W'($urandom);
          holding  = pi_valid;
          hold_dir = 1'b0;
        end
      end
    end

    always @(negedge clk) begin : mon
      exp_t e;
      bit   ev;
      q_left = exp_q.size();
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
        ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check($sformatf("c%0d_so_valid", IDX), 32'(so_valid), 32'(ev));
        check($sformatf("c%0d_pi_ready", IDX), 32'(pi_ready), 32'(cyc >= ready_from));
        check($sformatf("c%0d_busy", IDX), 32'(busy), 32'(cyc <= busy_until));
        if (ev) begin
          e = exp_q.pop_front();
          check($sformatf("c%0d_so", IDX), 32'(so), 32'(e.b));
          check($sformatf("c%0d_so_first", IDX), 32'(so_first), 32'(e.f));
          check($sformatf("c%0d_so_last", IDX), 32'(so_last), 32'(e.l));
        end else begin
          check($sformatf("c%0d_so_idle", IDX), 32'({so, so_first, so_last}), 32'(0));
        end
        q_left = exp_q.size();
      end
    end
  end

  initial begin : main
    bit got;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst    = 1'b1;
    mon_en = 1'b1;

    repeat (400) @(posedge clk);

    // Mid-frame reset on cfg0 after its second bit is on the line.
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (g_cfg[0].so_valid === 1'b1 && g_cfg[0].so_first === 1'b1) got = 1'b1;
    end
    check("rst_arm_frame_seen", 32'(got), 32'(1));
    @(posedge clk);
    #2;
    check("rst_pre_busy", 32'(g_cfg[0].busy), 32'(1));
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_so", 32'(g_cfg[0].so), 32'(0));
    check("rst_async_so_valid", 32'(g_cfg[0].so_valid), 32'(0));
    check("rst_async_busy", 32'(g_cfg[0].busy), 32'(0));
    check("rst_async_markers", 32'({g_cfg[0].so_first, g_cfg[0].so_last}), 32'(0));
    check("rst_async_pi_ready", 32'(g_cfg[0].pi_ready), 32'(1));
    check("rst_async_c2_busy", 32'(g_cfg[2].busy), 32'(0));
    check("rst_async_c2_valid", 32'(g_cfg[2].so_valid), 32'(0));
    @(posedge clk);
    #3;
    rst = 1'b1;

    repeat (300) @(posedge clk);
    drv_en = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    #1;
    check("c0_drained", 32'(g_cfg[0].q_left), 32'(0));
    check("c1_drained", 32'(g_cfg[1].q_left), 32'(0));
    check("c2_drained", 32'(g_cfg[2].q_left), 32'(0));
    check("c3_drained", 32'(g_cfg[3].q_left), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
